// File: rtl/mat_inv.sv
// mat_inv: sequential inverter for the symmetric 2x2 matrix A = [[sig0,sig1],[sig1,sig2]].
//   det = sig0*sig2 - sig1^2 is normalized to a 16-bit mantissa m. A radix-4 restoring
//   divider forms q = floor(2^31/m). The scaled adjugate entries come out with shared exponent p:
//     A^-1[0][0] ~ out0*2^-p, A^-1[0][1] ~ -out1*2^-p, A^-1[1][1] ~ out2*2^-p.
// Ports:
//   clk, rst_n (synchronous, active-high reset), start (sampled in IDLE only)
//   sig0[20:0], sig1[19:0], sig2[31:0]   Gram sums, captured on the start edge
//   out0[31:0], out1[19:0], out2[20:0], p[5:0], o_valid (one-cycle pulse)
//   counter[2:0], test[15:0]             debug taps
// Build option: define MAT_INV_DEBUG_EN to drive test with m and counter with the
//   DIV step index. Otherwise both are tied to 0; the datapath and latency do not change.
module mat_inv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [20:0] sig0,
  input  logic [19:0] sig1,
  input  logic [31:0] sig2,
  output logic [31:0] out0,
  output logic [19:0] out1,
  output logic [20:0] out2,
  output logic [5:0]  p,
  output logic [2:0]  counter,
  output logic [15:0] test,
  output logic        o_valid
);

  typedef enum logic [2:0] {IDLE, DET, NORM, DIV, MUL} state_t;

  state_t      state_q, state_d;
  logic [20:0] s0_q, s0_d;
  logic [19:0] s1_q, s1_d;
  logic [31:0] s2_q, s2_d;
  logic [53:0] det_q, det_d;
  logic [5:0]  pint_q, pint_d;
  logic [15:0] m_q, m_d;
  logic        pow2_q, pow2_d;
  logic        sing_q, sing_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [31:0] out0_q, out0_d;
  logic [19:0] out1_q, out1_d;
  logic [20:0] out2_q, out2_d;
  logic [5:0]  p_q, p_d;
  logic        vld_q, vld_d;

  // combinational helpers
  logic [5:0]  lead;
  logic [53:0] norm_sh;
  logic        det_sing;
  logic [17:0] rem_sh, m1, m2, m3;
  logic [16:0] q;
  logic [48:0] prod0;
  logic [36:0] prod1;
  logic [37:0] prod2;
  logic        unused_bits;

  // Leading-one position and normalized mantissa of the registered det.
  always_comb begin
    lead = '0;
    for (int i = 0; i < 53; i++)
      if (det_q[i]) lead = 6'(i);
    if (lead >= 6'd15) norm_sh = det_q >> (lead - 6'd15);
    else               norm_sh = det_q << (6'd15 - lead);
    // Two's-complement det: negative or zero means A is singular.
    det_sing = det_q[53] || (det_q == '0);
  end

  // Divider step. The remainder is always < m < 2^16, so four times it fits in 18 bits.
  always_comb begin
    rem_sh = {rem_q, 2'b00};
    m1     = {2'b00, m_q};
    m2     = {1'b0, m_q, 1'b0};
    m3     = m1 + m2;
  end

  // Output products. q never exceeds 2^16, so each result fits its port after >>16.
  always_comb begin
    q     = pow2_q ? 17'h10000 : {1'b0, quo_q};
    prod0 = 49'(s2_q) * 49'(q);
    prod1 = 37'(s1_q) * 37'(q);
    prod2 = 38'(s0_q) * 38'(q);
  end

  assign unused_bits = ^{prod0[48], prod0[15:0], prod1[36], prod1[15:0],
                         prod2[37], prod2[15:0], norm_sh[53:16]};

  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    det_d   = det_q;
    pint_d  = pint_q;
    m_d     = m_q;
    pow2_d  = pow2_q;
    sing_d  = sing_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    p_d     = p_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        s0_d    = sig0;
        s1_d    = sig1;
        s2_d    = sig2;
        state_d = DET;
      end
      DET: begin
        // Modulo-2^54 arithmetic gives the signed det directly.
        det_d   = 54'(s0_q) * 54'(s2_q) - 54'(s1_q) * 54'(s1_q);
        state_d = NORM;
      end
      NORM: begin
        sing_d  = det_sing;
        pint_d  = det_sing ? 6'd0 : lead;
        m_d     = det_sing ? 16'd0 : norm_sh[15:0];
        pow2_d  = !det_sing && (norm_sh[15:0] == 16'h8000);
        cnt_d   = '0;
        // The top 16 dividend bits of 2^31 give quotient zero, so the loop starts
        // with remainder 2^15. The remaining dividend bits are all zero.
        rem_d   = 16'h8000;
        quo_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        if (rem_sh >= m3) begin
          rem_d = 16'(rem_sh - m3);
          quo_d = {quo_q[13:0], 2'd3};
        end else if (rem_sh >= m2) begin
          rem_d = 16'(rem_sh - m2);
          quo_d = {quo_q[13:0], 2'd2};
        end else if (rem_sh >= m1) begin
          rem_d = 16'(rem_sh - m1);
          quo_d = {quo_q[13:0], 2'd1};
        end else begin
          rem_d = rem_sh[15:0];
          quo_d = {quo_q[13:0], 2'd0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = MUL;
      end
      MUL: begin
        out0_d  = sing_q ? 32'd0 : prod0[47:16];
        out1_d  = sing_q ? 20'd0 : prod1[35:16];
        out2_d  = sing_q ? 21'd0 : prod2[36:16];
        p_d     = sing_q ? 6'd0 : pint_q;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      det_q   <= '0;
      pint_q  <= '0;
      m_q     <= '0;
      pow2_q  <= 1'b0;
      sing_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      p_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      det_q   <= det_d;
      pint_q  <= pint_d;
      m_q     <= m_d;
      pow2_q  <= pow2_d;
      sing_q  <= sing_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      p_q     <= p_d;
      vld_q   <= vld_d;
    end
  end

  assign out0    = out0_q;
  assign out1    = out1_q;
  assign out2    = out2_q;
  assign p       = p_q;
  assign o_valid = vld_q;

`ifdef MAT_INV_DEBUG_EN
  assign test    = m_q;
  assign counter = (state_q == DIV) ? cnt_q : 3'd0;
`else
  assign test    = 16'd0;
  assign counter = 3'd0;
`endif

endmodule

// File: tb/tb_mat_inv.sv
// Directed bench for mat_inv: reset state, hand-computed vectors, singular inputs,
// a start pulse ignored mid-operation, reset abort mid-DIV, and the debug taps.
module tb_mat_inv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [20:0] sig0 = '0;
  logic [19:0] sig1 = '0;
  logic [31:0] sig2 = '0;
  logic [31:0] out0;
  logic [19:0] out1;
  logic [20:0] out2;
  logic [5:0]  p;
  logic [2:0]  counter;
  logic [15:0] test;
  logic        o_valid;

  int n_chk = 0;
  int n_err = 0;

`ifdef MAT_INV_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  mat_inv dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sig0(sig0), .sig1(sig1), .sig2(sig2),
    .out0(out0), .out1(out1), .out2(out2), .p(p),
    .counter(counter), .test(test), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands for the capture edge (E0), then scramble them so that only
  // values captured on that edge can influence the result.
  task automatic launch(input logic [20:0] a, input logic [19:0] b, input logic [31:0] c);
    sig0 = a; sig1 = b; sig2 = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sig0 = '1; sig1 = '1; sig2 = '1;
  endtask

  // Step edges E1..; optionally pulse start or reset before a given edge. Returns the
  // edge index at which o_valid was seen (0 if never), and the counter after E5.
  task automatic wait_valid(input int st_edge, input int rst_edge, output int lat,
                            output logic [2:0] c5);
    lat = 0;
    c5  = '0;
    for (int n = 1; n <= 30; n++) begin
      start = (n == st_edge);
      rst_n = (n == rst_edge);
      @(posedge clk); #1;
      if (n == 5) c5 = counter;
      if (o_valid) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    rst_n = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [20:0] a, input logic [19:0] b,
                         input logic [31:0] c, input logic [31:0] e0, input logic [19:0] e1,
                         input logic [20:0] e2, input logic [5:0] ep, input logic [15:0] em,
                         input int st_edge);
    int lat;
    logic [2:0] c5;
    launch(a, b, c);
    wait_valid(st_edge, 0, lat, c5);
    chk({tag, ".lat"}, 64'(lat), 64'd11);
    chk({tag, ".out0"}, 64'(out0), 64'(e0));
    chk({tag, ".out1"}, 64'(out1), 64'(e1));
    chk({tag, ".out2"}, 64'(out2), 64'(e2));
    chk({tag, ".p"}, 64'(p), 64'(ep));
    chk({tag, ".test"}, 64'(test), DBG ? 64'(em) : 64'd0);
    chk({tag, ".cnt5"}, 64'(c5), DBG ? 64'd3 : 64'd0);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(o_valid), 64'd0);
    chk({tag, ".hold0"}, 64'(out0), 64'(e0));
  endtask

  initial begin
    int lat;
    int extra;
    logic [2:0] c5;

    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out0", 64'(out0), 64'd0);
    chk("rst.out1", 64'(out1), 64'd0);
    chk("rst.out2", 64'(out2), 64'd0);
    chk("rst.p", 64'(p), 64'd0);
    chk("rst.counter", 64'(counter), 64'd0);
    chk("rst.test", 64'(test), 64'd0);
    chk("rst.valid", 64'(o_valid), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // det=4096, m=0x8000 takes the q=2^16 shortcut
    run_vec("v1", 21'd1, 20'd64, 32'd8192, 32'd8192, 20'd64, 21'd1, 6'd12, 16'h8000, 0);
    // det=1: smallest nonsingular det, p=0
    run_vec("v2", 21'd1, 20'd0, 32'd1, 32'd1, 20'd0, 21'd1, 6'd0, 16'h8000, 0);
    // det=15, m=61440, q=34952
    run_vec("v3", 21'd3, 20'd0, 32'd5, 32'd2, 20'd0, 21'd1, 6'd3, 16'd61440, 0);
    // det=600, m=38400, q=55924, nonzero off-diagonal
    run_vec("v4", 21'd10, 20'd20, 32'd100, 32'd85, 20'd17, 21'd8, 6'd9, 16'd38400, 0);
    // det=1e8, p=26, right-shift normalization, m=48828, q=43980
    run_vec("v5", 21'd1000, 20'd0, 32'd100000, 32'd67108, 20'd0, 21'd671, 6'd26, 16'd48828, 0);
    // det=0: singular
    run_vec("sing0", 21'd2, 20'd4, 32'd8, 32'd0, 20'd0, 21'd0, 6'd0, 16'd0, 0);
    // det=-3: singular
    run_vec("singn", 21'd1, 20'd2, 32'd1, 32'd0, 20'd0, 21'd0, 6'd0, 16'd0, 0);

    // start pulse at E4 must be ignored: one result, then nothing more
    run_vec("ign", 21'd1, 20'd64, 32'd8192, 32'd8192, 20'd64, 21'd1, 6'd12, 16'h8000, 4);
    extra = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (o_valid) extra++;
    end
    chk("ign.extra", 64'(extra), 64'd0);

    // reset at E6 (mid-DIV) aborts: no pulse, outputs cleared
    launch(21'd10, 20'd20, 32'd100);
    wait_valid(0, 6, lat, c5);
    chk("abort.valid", 64'(lat), 64'd0);
    chk("abort.out0", 64'(out0), 64'd0);
    chk("abort.out1", 64'(out1), 64'd0);
    chk("abort.out2", 64'(out2), 64'd0);
    chk("abort.p", 64'(p), 64'd0);
    chk("abort.test", 64'(test), 64'd0);

    // block still usable after the abort
    run_vec("post", 21'd3, 20'd0, 32'd5, 32'd2, 20'd0, 21'd1, 6'd3, 16'd61440, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
